// File: rtl/uart_param_si_pkg.sv
// uart_param_pkg: register map, control-register layout and FSM state types shared by the UART slice
package uart_param_pkg;
    localparam logic [3:0] ADDR_CR = 4'h0;
    localparam logic [3:0] ADDR_DR = 4'h4;
    localparam logic [3:0] ADDR_DV = 4'h8;
    localparam logic [3:0] ADDR_SR = 4'hC;
    localparam int CR_TR_EN    = 0;
    localparam int CR_REC_EN   = 1;
    localparam int CR_TX_FULL  = 2;
    localparam int CR_RX_VALID = 3;
    localparam int CR_PAR_EN   = 4;
    localparam int CR_PAR_ODD  = 5;
    localparam int CR_STOP2    = 6;
    localparam int CR_OVERRUN  = 7;
    localparam int CR_PAR_ERR  = 8;
    localparam int CR_FRM_ERR  = 9;
    typedef struct packed {
        logic frm_err;
        logic par_err;
        logic overrun;
        logic stop2;
        logic par_odd;
        logic par_en;
        logic rx_valid;
        logic tx_full;
        logic rec_en;
        logic tr_en;
    } uart_cr_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_param_si_if.sv
// uart_param_si_if: simple register bus (addr/re/we/wd/rd) between a bus master and a peripheral
interface uart_param_si_if;
    logic [3:0]  addr;
    logic        re;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    modport master (output addr, re, we, wd, input rd);
    modport slave (input addr, re, we, wd, output rd);
endinterface

// File: rtl/uart_param_si_fifo.sv
// uart_fifo: synchronous FIFO with level output; a push while full is accepted only alongside a pop
module uart_fifo #(
    parameter int DW = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   lvl
);
    localparam int AW = $clog2(DEPTH);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign empty = lvl == '0;
    assign full = lvl == (AW+1)'(DEPTH);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata = mem[rp];
    always_ff @(posedge clk or posedge rstn)
        if (rstn) begin
            wp <= '0;
            rp <= '0;
            lvl <= '0;
        end else begin
            wp <= do_push ? wp + AW'(1) : wp;
            rp <= do_pop ? rp + AW'(1) : rp;
            lvl <= lvl + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/uart_param_si.sv
// uart_param_si: parametrised UART with TX/RX FIFOs, optional parity, 1/2 stop bits and sticky errors
module uart_param_si
    import uart_param_pkg::*;
#(
    parameter int DW = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic           clk,
    input  logic           rstn,
    uart_param_si_if.slave bus,
    output logic           uart_tx,
    input  logic           uart_rx
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(DW);
    uart_cr_t cr;
    logic [DIV_W-1:0] dv, tx_cnt, rx_cnt;
    logic [LW-1:0] tx_lvl, rx_lvl;
    logic [DW-1:0] tx_head, rx_head, tx_sh, rx_sh;
    logic [BW-1:0] tx_bit, rx_bit;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_par, tx_stop2, rx_par, rx_s1, rx_s2, rx_q;
    tx_state_t tx_st;
    rx_state_t rx_st;
    logic wr_cr, wr_dv, tx_push, tx_pop, rx_pop, rx_samp, par_set, frm_set, rx_push, ovr_set;
    assign wr_cr = bus.we && bus.addr == ADDR_CR;
    assign wr_dv = bus.we && bus.addr == ADDR_DV;
    assign tx_push = bus.we && bus.addr == ADDR_DR;
    assign rx_pop = bus.re && bus.addr == ADDR_DR;
    assign tx_pop = tx_st == TX_IDLE && cr.tr_en && !tx_empty;
    // The whole RX verdict is taken at the first stop-bit sample
    assign rx_samp = rx_st == RX_STOP && rx_cnt == '0;
    assign frm_set = rx_samp && !rx_s2;
    assign par_set = rx_samp && rx_s2 && cr.par_en && (rx_par != (^rx_sh ^ cr.par_odd));
    assign rx_push = rx_samp && rx_s2 && !par_set;
    assign ovr_set = rx_push && rx_full && !rx_pop;
    uart_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk, .rstn, .push(tx_push), .pop(tx_pop), .wdata(bus.wd[DW-1:0]),
        .rdata(tx_head), .full(tx_full), .empty(tx_empty), .lvl(tx_lvl)
    );
    uart_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk, .rstn, .push(rx_push), .pop(rx_pop), .wdata(rx_sh),
        .rdata(rx_head), .full(rx_full), .empty(rx_empty), .lvl(rx_lvl)
    );
    assign bus.rd = bus.addr == ADDR_CR ? (32'(cr) | (32'(tx_full) << CR_TX_FULL) | (32'(!rx_empty) << CR_RX_VALID)) :
                    bus.addr == ADDR_DR ? (rx_empty ? 32'd0 : 32'(rx_head)) :
                    bus.addr == ADDR_DV ? 32'(dv) :
                    bus.addr == ADDR_SR ? {15'd0, tx_st != TX_IDLE, 8'(rx_lvl), 8'(tx_lvl)} : 32'd0;
    always_ff @(posedge clk or posedge rstn)
        if (rstn) begin
            cr <= '0;
            dv <= '0;
        end else begin
            if (wr_cr) begin
                cr.tr_en <= bus.wd[CR_TR_EN];
                cr.rec_en <= bus.wd[CR_REC_EN];
                cr.par_en <= bus.wd[CR_PAR_EN];
                cr.par_odd <= bus.wd[CR_PAR_ODD];
                cr.stop2 <= bus.wd[CR_STOP2];
            end
            cr.overrun <= (cr.overrun && !(wr_cr && bus.wd[CR_OVERRUN])) || ovr_set;
            cr.par_err <= (cr.par_err && !(wr_cr && bus.wd[CR_PAR_ERR])) || par_set;
            cr.frm_err <= (cr.frm_err && !(wr_cr && bus.wd[CR_FRM_ERR])) || frm_set;
            if (wr_dv) dv <= bus.wd[DIV_W-1:0];
        end
    // Bit counters count down from a fresh DV at every bit boundary, so DV changes land there
    always_ff @(posedge clk or posedge rstn)
        if (rstn) begin
            tx_st <= TX_IDLE;
            uart_tx <= 1'b1;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh <= '0;
            tx_par <= 1'b0;
            tx_stop2 <= 1'b0;
        end else begin
            case (tx_st)
                TX_IDLE: if (tx_pop) begin
                    tx_st <= TX_START;
                    uart_tx <= 1'b0;
                    tx_cnt <= dv;
                    tx_bit <= '0;
                    tx_sh <= tx_head;
                    tx_par <= ^tx_head ^ cr.par_odd;
                end
                TX_START: if (tx_cnt != '0) tx_cnt <= tx_cnt - DIV_W'(1);
                else begin
                    tx_st <= TX_DATA;
                    uart_tx <= tx_sh[0];
                    tx_cnt <= dv;
                end
                TX_DATA: if (tx_cnt != '0) tx_cnt <= tx_cnt - DIV_W'(1);
                else begin
                    tx_cnt <= dv;
                    if (tx_bit == BW'(DW-1)) begin
                        tx_st <= cr.par_en ? TX_PARITY : TX_STOP;
                        uart_tx <= cr.par_en ? tx_par : 1'b1;
                        tx_stop2 <= cr.stop2;
                    end else begin
                        tx_bit <= tx_bit + BW'(1);
                        tx_sh <= tx_sh >> 1;
                        uart_tx <= tx_sh[1];
                    end
                end
                TX_PARITY: if (tx_cnt != '0) tx_cnt <= tx_cnt - DIV_W'(1);
                else begin
                    tx_st <= TX_STOP;
                    uart_tx <= 1'b1;
                    tx_cnt <= dv;
                    tx_stop2 <= cr.stop2;
                end
                TX_STOP: if (tx_cnt != '0) tx_cnt <= tx_cnt - DIV_W'(1);
                else if (tx_stop2) begin
                    tx_stop2 <= 1'b0;
                    tx_cnt <= dv;
                end else tx_st <= TX_IDLE;
                default: tx_st <= TX_IDLE;
            endcase
        end
    always_ff @(posedge clk or posedge rstn)
        if (rstn) {rx_s1, rx_s2, rx_q} <= 3'b111;
        else {rx_s1, rx_s2, rx_q} <= {uart_rx, rx_s1, rx_s2};
    always_ff @(posedge clk or posedge rstn)
        if (rstn) begin
            rx_st <= RX_IDLE;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_sh <= '0;
            rx_par <= 1'b0;
        end else begin
            case (rx_st)
                RX_IDLE: if (cr.rec_en && rx_q && !rx_s2) begin
                    rx_st <= RX_START;
                    rx_cnt <= dv >> 1;
                end
                RX_START: if (rx_cnt != '0) rx_cnt <= rx_cnt - DIV_W'(1);
                else if (rx_s2) rx_st <= RX_IDLE;
                else begin
                    rx_st <= RX_DATA;
                    rx_cnt <= dv;
                    rx_bit <= '0;
                end
                RX_DATA: if (rx_cnt != '0) rx_cnt <= rx_cnt - DIV_W'(1);
                else begin
                    rx_cnt <= dv;
                    rx_sh <= {rx_s2, rx_sh[DW-1:1]};
                    if (rx_bit == BW'(DW-1)) rx_st <= cr.par_en ? RX_PARITY : RX_STOP;
                    else rx_bit <= rx_bit + BW'(1);
                end
                RX_PARITY: if (rx_cnt != '0) rx_cnt <= rx_cnt - DIV_W'(1);
                else begin
                    rx_par <= rx_s2;
                    rx_st <= RX_STOP;
                    rx_cnt <= dv;
                end
                RX_STOP: if (rx_cnt != '0) rx_cnt <= rx_cnt - DIV_W'(1);
                else rx_st <= RX_IDLE;
                default: rx_st <= RX_IDLE;
            endcase
        end
endmodule

// File: tb/tb_uart_param_si.sv
// tb_uart_param_si: directed and randomized checks of uart_param_si against a frame-level model
module tb_uart_param_si;
    import uart_param_pkg::*;
    logic clk = 1'b0, rstn = 1'b1, rx_drv = 1'b1, loop = 1'b1;
    logic uart_tx, uart_rx;
    int errs = 0, checks = 0;
    uart_param_si_if bus();
    uart_param_si dut (.clk(clk), .rstn(rstn), .bus(bus), .uart_tx(uart_tx), .uart_rx(uart_rx));
    assign uart_rx = loop ? uart_tx : rx_drv;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.addr = a; bus.wd = d; bus.we = 1'b1;
        @(posedge clk); #1;
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.addr = a; bus.re = 1'b1;
        #1 d = bus.rd;
        @(posedge clk); #1;
        bus.re = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        chk(tag, v, exp);
    endtask

    task automatic get_rx(input string tag, input logic [7:0] exp);
        logic [31:0] v;
        int n = 0;
        do begin rd(ADDR_CR, v); n++; end while (!v[3] && n < 4000);
        chk({tag, " rx_valid"}, 32'(v[3]), 32'd1);
        rd_chk({tag, " data"}, ADDR_DR, 32'(exp));
    endtask

    task automatic put_tx(input logic [7:0] d);
        logic [31:0] v;
        int n = 0;
        do begin rd(ADDR_CR, v); n++; end while (v[2] && n < 4000);
        chk("tx space", 32'(v[2]), 32'd0);
        wr(ADDR_DR, 32'(d));
    endtask

    task automatic wait_idle();
        logic [31:0] v;
        int n = 0;
        do begin rd(ADDR_SR, v); n++; end while ((v[16] || v[7:0] != 8'd0) && n < 4000);
        chk("tx drained", {15'd0, v[16], 8'd0, v[7:0]}, 32'd0);
        repeat (24) @(negedge clk);
    endtask

    // Expected line levels come from the frame rules: start, LSB-first data, parity, stop bits
    task automatic check_frame(input logic [7:0] d, input logic pe, po, s2, input int p);
        logic q[$];
        int n = 0;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (pe) q.push_back(^d ^ po);
        q.push_back(1'b1);
        if (s2) q.push_back(1'b1);
        while (uart_tx !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
        chk("frame start", 32'(uart_tx), 32'd0);
        for (int k = 0; k < q.size(); k++)
            for (int j = 0; j < p; j++) begin
                chk($sformatf("frame %02h bit %0d", d, k), 32'(uart_tx), 32'(q[k]));
                @(negedge clk);
            end
    endtask

    task automatic send_raw(input logic [7:0] d, input logic par, stop, input int p);
        rx_drv = 1'b0;
        repeat (p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin rx_drv = d[i]; repeat (p) @(negedge clk); end
        rx_drv = par;
        repeat (p) @(negedge clk);
        rx_drv = stop;
        repeat (p) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * p) @(negedge clk);
    endtask

    initial begin
        automatic string hello = "Hello World!\n";
        logic [7:0] sent[$];
        logic [7:0] d;
        logic pe, po, s2;
        int dvv;
        bus.addr = '0; bus.re = 1'b0; bus.we = 1'b0; bus.wd = '0;
        repeat (3) @(negedge clk);
        chk("reset uart_tx", 32'(uart_tx), 32'd1);
        rstn = 1'b0;
        rd_chk("reset CR", ADDR_CR, 32'd0);
        rd_chk("reset DV", ADDR_DV, 32'd0);
        rd_chk("reset SR", ADDR_SR, 32'd0);
        rd_chk("reset DR empty", ADDR_DR, 32'd0);

        for (int i = 0; i < 5; i++) wr(ADDR_DR, 32'(8'h21 + i));
        rd_chk("tx full CR", ADDR_CR, 32'h4);
        rd_chk("tx full SR", ADDR_SR, 32'h4);
        repeat (20) @(negedge clk);
        chk("tx disabled line", 32'(uart_tx), 32'd1);
        wr(ADDR_DV, 32'd3);
        wr(ADDR_CR, 32'h3);
        wait_idle();
        for (int i = 0; i < 4; i++) rd_chk($sformatf("drained byte %0d", i), ADDR_DR, 32'(8'h21 + i));
        rd_chk("fifth dropped CR", ADDR_CR, 32'h3);
        rd_chk("empty DR read", ADDR_DR, 32'd0);

        wr(ADDR_DV, 32'h80);
        for (int i = 0; i < hello.len(); i++) begin
            wr(ADDR_DR, 32'(hello[i]));
            get_rx($sformatf("hello %0d", i), hello[i]);
        end
        rd_chk("hello no errors", ADDR_CR, 32'h3);

        wr(ADDR_DV, 32'd3);
        wr(ADDR_CR, 32'h53);
        wr(ADDR_DR, 32'hA5);
        check_frame(8'hA5, 1'b1, 1'b0, 1'b1, 4);
        get_rx("A5", 8'hA5);

        for (int r = 0; r < 8; r++) begin
            d = 8'($urandom);
            pe = 1'($urandom_range(0, 1));
            po = 1'($urandom_range(0, 1));
            s2 = 1'($urandom_range(0, 1));
            dvv = $urandom_range(2, 7);
            wr(ADDR_DV, 32'(dvv));
            wr(ADDR_CR, {25'd0, s2, po, pe, 4'b0011});
            wr(ADDR_DR, 32'(d));
            check_frame(d, pe, po, s2, dvv + 1);
            get_rx($sformatf("rand %0d", r), d);
            rd_chk($sformatf("rand %0d CR", r), ADDR_CR, {25'd0, s2, po, pe, 4'b0011});
        end

        wr(ADDR_DV, 32'd3);
        wr(ADDR_CR, 32'h3);
        wait_idle();
        sent.delete();
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            sent.push_back(d);
            put_tx(d);
        end
        wait_idle();
        rd_chk("overrun SR", ADDR_SR, 32'h400);
        rd_chk("overrun CR", ADDR_CR, 32'h8B);
        for (int i = 0; i < 4; i++) rd_chk($sformatf("overrun byte %0d", i), ADDR_DR, 32'(sent[i]));
        rd_chk("overrun empty DR", ADDR_DR, 32'd0);
        wr(ADDR_CR, 32'h83);
        rd_chk("overrun cleared", ADDR_CR, 32'h3);

        loop = 1'b0;
        wr(ADDR_CR, 32'h32);
        d = 8'h3A;
        send_raw(d, ~(^d ^ 1'b1), 1'b1, 4);
        rd_chk("par_err set", ADDR_CR, 32'h132);
        wr(ADDR_CR, 32'h132);
        rd_chk("par_err cleared", ADDR_CR, 32'h32);
        send_raw(d, ^d ^ 1'b1, 1'b0, 4);
        rd_chk("frm_err set", ADDR_CR, 32'h232);
        wr(ADDR_CR, 32'h232);
        rd_chk("frm_err cleared", ADDR_CR, 32'h32);
        send_raw(8'hC4, ^8'hC4 ^ 1'b1, 1'b1, 4);
        get_rx("odd parity good", 8'hC4);

        loop = 1'b1;
        wr(ADDR_DV, 32'd7);
        wr(ADDR_CR, 32'h1);
        wr(ADDR_DR, 32'h55);
        wr(ADDR_DR, 32'h11);
        begin
            int n = 0;
            while (uart_tx !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
        end
        repeat (4 + 16) @(negedge clk);
        chk("mid data line low", 32'(uart_tx), 32'd0);
        rstn = 1'b1;
        #1 chk("reset forces idle", 32'(uart_tx), 32'd1);
        rd_chk("reset SR", ADDR_SR, 32'd0);
        rd_chk("reset CR again", ADDR_CR, 32'd0);
        @(negedge clk);
        rstn = 1'b0;
        wr(ADDR_DV, 32'd3);
        wr(ADDR_CR, 32'h3);
        wr(ADDR_DR, 32'h3C);
        check_frame(8'h3C, 1'b0, 1'b0, 1'b0, 4);
        get_rx("after reset", 8'h3C);
        repeat (8) @(negedge clk);
        rd_chk("after reset SR", ADDR_SR, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
